// File: rtl/flag_fifo_buf.sv
//==============================================================================
// Module   : flag_fifo_buf
// Brief    : DEPTH-entry FWFT receive buffer with occupancy, almost-full and sticky overrun.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module flag_fifo_buf #(
    parameter int W        = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       set_flag,
    input  logic [W-1:0]               din,
    input  logic                       clr_flag,
    input  logic                       ovr_clr,
    output logic                       flag,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overrun,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] c_ptr_one   = PW'(1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);
    localparam logic [CW-1:0] c_cnt_full  = CW'(DEPTH);
    localparam logic [CW-1:0] c_cnt_af    = CW'(AF_LEVEL);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("flag_fifo_buf: DEPTH must be a power of 2 and >= 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
            $error("flag_fifo_buf: AF_LEVEL must lie in 1..DEPTH");
        end
    endgenerate

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;

    logic          w_do_pop;
    logic          w_do_push;
    logic          w_drop;

    assign flag        = (count_q != '0);
    assign full        = (count_q == c_cnt_full);
    assign almost_full = (count_q >= c_cnt_af);
    assign overrun     = overrun_q;
    assign count       = count_q;
    assign dout        = flag ? mem_q[rd_ptr_q] : '0;

    // A pop frees the slot in the same cycle, so a full buffer still accepts a push alongside it.
    assign w_do_pop  = clr_flag & flag;
    assign w_do_push = set_flag & (~full | w_do_pop);
    assign w_drop    = set_flag & full & ~w_do_pop;

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (w_do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + c_ptr_one;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + c_cnt_one;
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - c_cnt_one;
        end

        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage carries no reset; the count gates dout so stale contents never leak.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_flag_fifo_buf.sv
//==============================================================================
// Module   : tb_flag_fifo_buf
// Brief    : Directed and randomized checks of flag_fifo_buf against a queue model.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_flag_fifo_buf;

    localparam int W        = 8;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          set_flag = 1'b0;
    logic [W-1:0]  din = '0;
    logic          clr_flag = 1'b0;
    logic          ovr_clr = 1'b0;
    logic          flag;
    logic [W-1:0]  dout;
    logic          full;
    logic          almost_full;
    logic          overrun;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] q[$];
    logic         m_ovr = 1'b0;
    int           max_count = 0;

    flag_fifo_buf #(.W(W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .set_flag    (set_flag),
        .din         (din),
        .clr_flag    (clr_flag),
        .ovr_clr     (ovr_clr),
        .flag        (flag),
        .dout        (dout),
        .full        (full),
        .almost_full (almost_full),
        .overrun     (overrun),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] e_dout;
        e_dout = (q.size() > 0) ? 32'(q[0]) : 32'h0;
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".flag"}, 32'(flag), 32'(q.size() != 0));
        chk({tag, ".dout"}, 32'(dout), e_dout);
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".af"}, 32'(almost_full), 32'(q.size() >= AF_LEVEL));
        chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    // Called at a falling edge; applies inputs across one rising edge and checks at the next fall.
    task automatic cyc(input logic s, input logic [W-1:0] d, input logic c, input logic oc,
                       input string tag);
        bit pop_ok, accept, drop;
        set_flag = s; din = d; clr_flag = c; ovr_clr = oc;
        @(posedge clk);
        pop_ok = c && (q.size() > 0);
        accept = s && ((q.size() < DEPTH) || pop_ok);
        drop   = s && !accept;
        if (pop_ok) void'(q.pop_front());
        if (accept) q.push_back(d);
        if (drop) m_ovr = 1'b1;
        else if (oc) m_ovr = 1'b0;
        if (q.size() > max_count) max_count = q.size();
        @(negedge clk);
        set_flag = 1'b0; clr_flag = 1'b0; ovr_clr = 1'b0;
        chk_model(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".flag"}, 32'(flag), 32'h0);
        chk({tag, ".count"}, 32'(count), 32'h0);
        chk({tag, ".dout"}, 32'(dout), 32'h0);
        chk({tag, ".ovr"}, 32'(overrun), 32'h0);
        chk({tag, ".full"}, 32'(full), 32'h0);
        chk({tag, ".af"}, 32'(almost_full), 32'h0);
    endtask

    initial begin
        // Reset held with a push request pending
        reset_n = 1'b0; set_flag = 1'b1; din = 8'h5A;
        repeat (3) @(negedge clk);
        chk_zero("reset_hold");
        set_flag = 1'b0;
        reset_n = 1'b1;

        // Single word round trip
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, "push_a5");
        chk("push_a5.dout_lit", 32'(dout), 32'hA5);
        chk("push_a5.count_lit", 32'(count), 32'h1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "pop_a5");
        chk("pop_a5.flag_lit", 32'(flag), 32'h0);
        chk("pop_a5.dout_lit", 32'(dout), 32'h0);

        // Fill, almost-full, full, overrun, drain in order
        cyc(1'b1, 8'h11, 1'b0, 1'b0, "fill11");
        cyc(1'b1, 8'h22, 1'b0, 1'b0, "fill22");
        chk("fill22.af_lit", 32'(almost_full), 32'h0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0, "fill33");
        chk("fill33.af_lit", 32'(almost_full), 32'h1);
        cyc(1'b1, 8'h44, 1'b0, 1'b0, "fill44");
        chk("fill44.full_lit", 32'(full), 32'h1);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, "drop55");
        chk("drop55.ovr_lit", 32'(overrun), 32'h1);
        chk("drop55.count_lit", 32'(count), 32'h4);
        chk("drain.head0", 32'(dout), 32'h11);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "drain1");
        chk("drain.head1", 32'(dout), 32'h22);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
        chk("drain.head2", 32'(dout), 32'h33);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "drain3");
        chk("drain.head3", 32'(dout), 32'h44);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "drain4");
        chk("drain4.flag_lit", 32'(flag), 32'h0);

        // Wrap-around with alternating push/pop
        max_count = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "wrap_push");
            chk("wrap.head", 32'(dout), 32'(8'hC0 + i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0, "wrap_pop");
        end
        chk("wrap.max_count", 32'(max_count), 32'h1);

        // Push+pop on a full buffer
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "ovr_clear_pre");
        cyc(1'b1, 8'h11, 1'b0, 1'b0, "refill11");
        cyc(1'b1, 8'h22, 1'b0, 1'b0, "refill22");
        cyc(1'b1, 8'h33, 1'b0, 1'b0, "refill33");
        cyc(1'b1, 8'h44, 1'b0, 1'b0, "refill44");
        cyc(1'b1, 8'h66, 1'b1, 1'b0, "full_pushpop");
        chk("full_pushpop.ovr_lit", 32'(overrun), 32'h0);
        chk("full_pushpop.count_lit", 32'(count), 32'h4);
        chk("full_pushpop.head_lit", 32'(dout), 32'h22);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "fp_pop1");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "fp_pop2");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "fp_pop3");
        chk("fp.last_lit", 32'(dout), 32'h66);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "fp_pop4");

        // Overrun set beats clear; clear alone works; pop on empty is harmless
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0, "ovr_fill");
        cyc(1'b1, 8'h77, 1'b0, 1'b0, "ovr_set");
        cyc(1'b1, 8'h78, 1'b0, 1'b1, "ovr_set_vs_clr");
        chk("ovr_set_vs_clr.lit", 32'(overrun), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "ovr_clr_alone");
        chk("ovr_clr_alone.lit", 32'(overrun), 32'h0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "ovr_drain");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "pop_empty");
        cyc(1'b1, 8'h3C, 1'b1, 1'b0, "empty_pushpop");
        chk("empty_pushpop.count_lit", 32'(count), 32'h1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "empty_pushpop_drain");

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                1'($urandom_range(0, 99) < 10), "rand");
        end

        // Asynchronous reset in mid-operation drops outputs at once
        cyc(1'b1, 8'h9E, 1'b0, 1'b0, "pre_rst");
        cyc(1'b1, 8'h9F, 1'b0, 1'b0, "pre_rst2");
        #2 reset_n = 1'b0;
        #1 chk_zero("async_rst");
        q.delete();
        m_ovr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 8'hE1, 1'b0, 1'b0, "post_rst");
        chk("post_rst.head_lit", 32'(dout), 32'hE1);
        chk("post_rst.count_lit", 32'(count), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
